// File: rtl/arb_pkg.sv
// Shared types for the round-robin interconnect arbiters.
package arb_pkg;

    localparam int NUM_M = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } Packet;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after 'last', wrapping, 'last' itself lowest.
module rr_pick (
    input  logic [3:0] REQ,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!valid && REQ[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mem_scheduler.sv
// Four-master round-robin scheduler in front of one memory port, with a no-ack watchdog.
module rr_mem_scheduler
    import arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_M-1:0]  REQ,
    input  Packet [NUM_M-1:0] master_in_data,
    output logic [NUM_M-1:0]  GNT,
    output Packet             master_out_data,
    output logic              mem_req,
    input  logic [31:0]       rdata,
    input  logic              rdata_ack,
    output logic [31:0]       slave_rdata,
    output logic              slave_rdata_ack,
    output logic [1:0]        slave_rdata_id,
    output logic              timeout_err
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  gnt_q, gnt_d;
    Packet             out_q, out_d;
    logic              mreq_q, mreq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic [1:0]        id_q, id_d;
    logic              err_q, err_d;
    logic [1:0]        cur_q, cur_d;
    logic [1:0]        last_q, last_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              pick_valid;
    logic [1:0]        pick_idx;

    rr_pick u_pick (
        .REQ   (REQ),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            out_q   <= '0;
            mreq_q  <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
            cur_q   <= '0;
            last_q  <= 2'd3;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            mreq_q  <= mreq_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        out_d   = out_q;
        mreq_d  = mreq_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        id_d    = id_q;
        err_d   = 1'b0;
        cur_d   = cur_q;
        last_d  = last_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                // Idle outputs sit at reset values; only slave_rdata keeps the last read.
                gnt_d  = '0;
                out_d  = '0;
                mreq_d = 1'b0;
                id_d   = '0;
                wd_d   = '0;
                if (pick_valid) begin
                    gnt_d   = NUM_M'(1) << pick_idx;
                    out_d   = master_in_data[pick_idx];
                    mreq_d  = 1'b1;
                    cur_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // An ack landing on the expiry cycle completes normally.
                if (rdata_ack) begin
                    rdata_d = rdata;
                    ack_d   = 1'b1;
                    id_d    = cur_q;
                    gnt_d   = '0;
                    mreq_d  = 1'b0;
                    last_d  = cur_q;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    mreq_d  = 1'b0;
                    last_d  = cur_q;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign GNT             = gnt_q;
    assign master_out_data = out_q;
    assign mem_req         = mreq_q;
    assign slave_rdata     = rdata_q;
    assign slave_rdata_ack = ack_q;
    assign slave_rdata_id  = id_q;
    assign timeout_err     = err_q;

endmodule

// File: tb/tb_rr_mem_scheduler.sv
// Scoreboard bench: stimulus predicts grants/completions, a negedge monitor checks them.
module tb_rr_mem_scheduler;
    import arb_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic [3:0] gnt;
        Packet      pkt;
    } gexp_t;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        logic [1:0]  id;
    } cexp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  REQ;
    Packet [3:0] master_in_data;
    logic [3:0]  GNT;
    Packet       master_out_data;
    logic        mem_req;
    logic [31:0] rdata;
    logic        rdata_ack;
    logic [31:0] slave_rdata;
    logic        slave_rdata_ack;
    logic [1:0]  slave_rdata_id;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    gexp_t gq[$];
    cexp_t cq[$];
    gexp_t cur_g;
    cexp_t mon_c;
    logic [3:0] prev_gnt;
    logic [1:0] last_m;

    always #5 clk = ~clk;

    rr_mem_scheduler #(.NUM_M(4), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .REQ             (REQ),
        .master_in_data  (master_in_data),
        .GNT             (GNT),
        .master_out_data (master_out_data),
        .mem_req         (mem_req),
        .rdata           (rdata),
        .rdata_ack       (rdata_ack),
        .slave_rdata     (slave_rdata),
        .slave_rdata_ack (slave_rdata_ack),
        .slave_rdata_id  (slave_rdata_id),
        .timeout_err     (timeout_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: scan masters starting just after the previous winner.
    function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] w;
        for (int i = 1; i <= 4; i++) begin
            w = 2'((int'(l) + i) % 4);
            if (r[w]) return w;
        end
        return l;
    endfunction

    task automatic rand_data();
        for (int m = 0; m < 4; m++)
            master_in_data[m] = {1'($urandom), $urandom, $urandom};
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after completion.
    task automatic run_txn(input logic [3:0] req, input int d, input logic [3:0] busy_req);
        logic [1:0]  w;
        logic [31:0] val;
        int          n;
        REQ = req;
        rand_data();
        w   = rr(req, last_m);
        val = $urandom;
        gq.push_back('{gnt: 4'(1) << w, pkt: master_in_data[w]});
        cq.push_back('{is_err: (d > TO), data: val, id: w});
        last_m = w;
        n = 1;
        @(negedge clk);
        REQ = busy_req;
        rand_data();
        forever begin
            rdata     = (n == d) ? val : $urandom;
            rdata_ack = (n == d);
            if (n == d || n == TO) break;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rdata_ack = 1'b0;
        chk("gnt_low_after_done", {GNT, mem_req}, 0);
    endtask

    task automatic idle(input int cyc, input logic poke);
        REQ = '0;
        for (int i = 0; i < cyc; i++) begin
            rdata_ack = poke && (i == 0);
            rdata     = $urandom;
            @(negedge clk);
            chk("idle_no_gnt", {GNT, mem_req}, 0);
        end
        rdata_ack = 1'b0;
    endtask

    // Monitor: checks grants and completions whenever the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            prev_gnt = '0;
        end else begin
            if (GNT != 0 && prev_gnt == 0) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got %b expected none", GNT);
                end else begin
                    cur_g = gq.pop_front();
                    chk("grant", GNT, cur_g.gnt);
                    chk("out_data", master_out_data, cur_g.pkt);
                    chk("mem_req", mem_req, 1);
                end
            end else if (GNT != 0) begin
                chk("gnt_hold", {GNT, master_out_data, mem_req}, {cur_g.gnt, cur_g.pkt, 1'b1});
            end
            if (slave_rdata_ack || timeout_err) begin
                chk("ack_err_excl", slave_rdata_ack & timeout_err, 0);
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got ack=%b err=%b expected none",
                             slave_rdata_ack, timeout_err);
                end else begin
                    mon_c = cq.pop_front();
                    chk("cpl_kind", {timeout_err, slave_rdata_ack}, {mon_c.is_err, ~mon_c.is_err});
                    if (!mon_c.is_err) begin
                        chk("rdata", slave_rdata, mon_c.data);
                        chk("rdata_id", slave_rdata_id, mon_c.id);
                    end
                end
            end
            prev_gnt = GNT;
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        reset     = 1'b0;
        REQ       = '0;
        rdata     = '0;
        rdata_ack = 1'b0;
        rand_data();
        last_m = 2'd3;
        repeat (3) @(negedge clk);
        chk("reset_vals", {GNT, mem_req, master_out_data, slave_rdata, slave_rdata_ack,
                           slave_rdata_id, timeout_err}, 0);
        reset = 1'b1;

        // Full contention, ack two cycles into each transaction.
        repeat (5) run_txn(4'b1111, 2, 4'b1111);
        // Ack in the first BUSY cycle.
        run_txn(4'b0100, 1, 4'b0000);
        // Master 1 drops REQ while busy; master 3 must win before master 0.
        run_txn(4'b0010, 3, 4'b1000);
        run_txn(4'b1001, 2, 4'b0000);
        // Watchdog abort, then the same master is served again.
        run_txn(4'b0001, 10, 4'b0001);
        run_txn(4'b0001, 1, 4'b0000);
        // Stray ack while idle.
        idle(3, 1'b1);

        // Reset in the middle of a transaction to master 3.
        REQ = 4'b1000;
        rand_data();
        gq.push_back('{gnt: 4'(1) << rr(4'b1000, last_m), pkt: master_in_data[rr(4'b1000, last_m)]});
        @(negedge clk);
        REQ = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_async_drop", {GNT, mem_req}, 0);
        last_m = 2'd3;
        @(negedge clk);
        reset = 1'b1;
        run_txn(4'b1001, 2, 4'b0000);

        repeat (80) begin
            r = 4'($urandom);
            if (r == 0) idle($urandom_range(1, 3), 1'($urandom));
            else run_txn(r, $urandom_range(1, 6), 4'($urandom));
        end
        idle(2, 1'b0);
        chk("queues_drained", gq.size() + cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
